// File: rtl/sisc_pkg.sv
// Shared constants for the SISC datapath: opcodes,
// instruction field positions, fetch FSM states.
package sisc_pkg;

  localparam int OPC_W = 4;
  localparam int MM_W  = 4;
  localparam int IMM_W = 16;
  localparam int ST_W  = 4;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;
  localparam int MM_MSB  = 27;
  localparam int MM_LSB  = 24;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [OPC_W-1:0] NOOP   = 4'd0;
  localparam logic [OPC_W-1:0] LOD    = 4'd1;
  localparam logic [OPC_W-1:0] STR    = 4'd2;
  localparam logic [OPC_W-1:0] SWP    = 4'd3;
  localparam logic [OPC_W-1:0] BRA    = 4'd4;
  localparam logic [OPC_W-1:0] BRR    = 4'd5;
  localparam logic [OPC_W-1:0] BNE    = 4'd6;
  localparam logic [OPC_W-1:0] BNR    = 4'd7;
  localparam logic [OPC_W-1:0] ALU_OP = 4'd8;
  localparam logic [OPC_W-1:0] HLT    = 4'd15;

  localparam logic [MM_W-1:0] AM_IMM = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_st_e;

endpackage

// File: rtl/sisc_branch_eval.sv
// Branch-condition evaluation on the current IR
// fields and status register.
module sisc_branch_eval
  import sisc_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  logic [MM_W-1:0]  mm,
  input  logic [ST_W-1:0]  stat,
  output logic             taken
);

  logic hit_set;
  logic hit_clr;
  logic any;

  assign hit_set = (opcode == BRA) || (opcode == BRR);
  assign hit_clr = (opcode == BNE) || (opcode == BNR);
  assign any     = |(stat & mm);

  // taken decode: set-branches need a masked flag, clear-branches none
  always_comb begin
    taken = 1'b0;
    unique case (1'b1)
      hit_set: taken = any;
      hit_clr: taken = ~any;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/sisc_fetch_unit.sv
// SISC fetch unit: PC, IR, status register and the
// imem req/ack fetch handshake with timeout.
module sisc_fetch_unit
  import sisc_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int IW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            pc_rst,
  input  logic            pc_write,
  input  logic            pc_sel,
  input  logic            br_sel,
  input  logic            ir_load,
  input  logic [3:0]      stat_in,
  input  logic            stat_en,
  input  logic            imem_ack,
  input  logic [IW-1:0]   imem_rdata,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  output logic [3:0]      opcode,
  output logic [3:0]      mm,
  output logic [3:0]      stat,
  output logic [IW-1:0]   ir,
  output logic [PC_W-1:0] pc,
  output logic            fetch_busy,
  output logic            fetch_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  fetch_st_e state_q, state_d;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [ST_W-1:0] stat_q, stat_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic                   taken;
  logic                   tmo;
  logic [IMM_W-1:0]       imm;
  logic signed [IMM_W-1:0] imm_s;
  logic [PC_W-1:0]        tgt_abs;
  logic [PC_W-1:0]        tgt_rel;

  assign imm     = ir_q[IMM_MSB:IMM_LSB];
  assign imm_s   = $signed(imm);
  assign tgt_abs = PC_W'(imm);
  assign tgt_rel = pc_q + PC_W'(imm_s);
  assign tmo     = (cnt_q == CW'(TIMEOUT));

  sisc_branch_eval u_br (
    .opcode (ir_q[OPC_MSB:OPC_LSB]),
    .mm     (ir_q[MM_MSB:MM_LSB]),
    .stat   (stat_q),
    .taken  (taken)
  );

  // fetch FSM state register
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // fetch FSM next state
  always_comb begin
    state_d = state_q;
    if (pc_rst) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (ir_load) state_d = REQ;
        REQ:  if (imem_ack || tmo) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // datapath next values driven by the FSM and ctrl commands
  always_comb begin
    pc_d   = pc_q;
    addr_d = addr_q;
    ir_d   = ir_q;
    stat_d = stat_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (pc_rst) begin
      pc_d  = '0;
      err_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ir_load) begin
            addr_d = pc_q;
            cnt_d  = '0;
          end
        end
        REQ: begin
          if (imem_ack) begin
            ir_d = imem_rdata;
          end else if (tmo) begin
            ir_d  = '0;
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
      if (pc_write) begin
        if (!pc_sel)    pc_d = pc_q + 1'b1;
        else if (taken) pc_d = br_sel ? tgt_abs : tgt_rel;
      end
      if (stat_en) stat_d = stat_in;
    end
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pc_q   <= '0;
      addr_q <= '0;
      ir_q   <= '0;
      stat_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      addr_q <= addr_d;
      ir_q   <= ir_d;
      stat_q <= stat_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign imem_req   = (state_q == REQ);
  assign imem_addr  = addr_q;
  assign ir         = ir_q;
  assign opcode     = ir_q[OPC_MSB:OPC_LSB];
  assign mm         = ir_q[MM_MSB:MM_LSB];
  assign stat       = stat_q;
  assign pc         = pc_q;
  assign fetch_err  = err_q;
  assign fetch_busy = (state_q == REQ)
                    | ((state_q == IDLE) & ir_load);

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Self-checking bench for sisc_fetch_unit:
// PC/branch vector table plus fetch sequences.
module tb_sisc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_f = 1'b0;
  logic        pc_rst = 1'b0;
  logic        pc_write = 1'b0;
  logic        pc_sel = 1'b0;
  logic        br_sel = 1'b0;
  logic        ir_load = 1'b0;
  logic [3:0]  stat_in = 4'h0;
  logic        stat_en = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [3:0]  stat;
  logic [31:0] ir;
  logic [15:0] pc;
  logic        fetch_busy;
  logic        fetch_err;

  int n_pass = 0;
  int n_total = 0;

  sisc_fetch_unit #(.PC_W(16), .IW(32), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .pc_rst     (pc_rst),
    .pc_write   (pc_write),
    .pc_sel     (pc_sel),
    .br_sel     (br_sel),
    .ir_load    (ir_load),
    .stat_in    (stat_in),
    .stat_en    (stat_en),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .opcode     (opcode),
    .mm         (mm),
    .stat       (stat),
    .ir         (ir),
    .pc         (pc),
    .fetch_busy (fetch_busy),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [15:0] pc0;
    logic [31:0] w;
    logic [3:0]  st;
    logic        ps;
    logic        bs;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch0(input logic [31:0] w);
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = w;
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic load_stat(input logic [3:0] s);
    stat_en = 1'b1;
    stat_in = s;
    tick();
    stat_en = 1'b0;
  endtask

  task automatic pcw(input logic ps, input logic bs);
    pc_write = 1'b1;
    pc_sel = ps;
    br_sel = bs;
    tick();
    pc_write = 1'b0;
    pc_sel = 1'b0;
    br_sel = 1'b0;
  endtask

  initial begin
    int busy_n;
    int ir_upd;
    int n;
    logic [31:0] prev;

    tv[0] = '{"bra_taken", 16'h0100, 32'h42000040, 4'h2, 1'b1, 1'b1, 16'h0040};
    tv[1] = '{"bne_not",   16'h0100, 32'h62000040, 4'h2, 1'b1, 1'b1, 16'h0100};
    tv[2] = '{"brr_neg",   16'h0010, 32'h5F00FFF0, 4'h1, 1'b1, 1'b0, 16'h0000};
    tv[3] = '{"inc_wrap",  16'hFFFF, 32'h00000000, 4'h0, 1'b0, 1'b0, 16'h0000};
    tv[4] = '{"bnr_rel",   16'h1000, 32'h74000020, 4'h2, 1'b1, 1'b0, 16'h1020};
    tv[5] = '{"bra_not",   16'h0200, 32'h44000300, 4'h2, 1'b1, 1'b1, 16'h0200};
    tv[6] = '{"alu_nobr",  16'h0300, 32'h8F001111, 4'hF, 1'b1, 1'b1, 16'h0300};
    tv[7] = '{"brr_wrap",  16'h8001, 32'h5F007FFF, 4'h1, 1'b1, 1'b0, 16'h0000};
    tv[8] = '{"inc_plain", 16'h1234, 32'h4F000005, 4'hF, 1'b0, 1'b0, 16'h1235};
    tv[9] = '{"bne_mm0",   16'h0100, 32'h60000ABC, 4'hF, 1'b1, 1'b1, 16'h0ABC};

    #12;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_stat", 32'(stat), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", 32'(imem_addr), 32'h0);
    chk("rst_err", 32'(fetch_err), 32'h0);
    chk("rst_busy", 32'(fetch_busy), 32'h0);
    rst_f = 1'b1;
    tick();

    // fetch with pc_write on the same edge, zero-wait ack
    ir_load = 1'b1;
    pc_write = 1'b1;
    #1;
    chk("f1_busy_ld", 32'(fetch_busy), 32'h1);
    tick();
    ir_load = 1'b0;
    pc_write = 1'b0;
    chk("f1_req", 32'(imem_req), 32'h1);
    chk("f1_addr", 32'(imem_addr), 32'h0);
    chk("f1_pc", 32'(pc), 32'h1);
    imem_ack = 1'b1;
    imem_rdata = 32'h81230005;
    tick();
    imem_ack = 1'b0;
    chk("f1_ir", ir, 32'h81230005);
    chk("f1_opc", 32'(opcode), 32'h8);
    chk("f1_mm", 32'(mm), 32'h1);
    chk("f1_req_dn", 32'(imem_req), 32'h0);
    chk("f1_busy_dn", 32'(fetch_busy), 32'h0);

    // 3-cycle memory wait, second ir_load in REQ, stray ack in IDLE
    busy_n = 0;
    ir_upd = 0;
    prev = ir;
    for (int k = 0; k < 8; k++) begin
      ir_load = (k == 0) || (k == 2);
      imem_ack = (k == 3) || (k == 5);
      imem_rdata = (k == 3) ? 32'h12345678 : 32'hDEADBEEF;
      #1;
      if (fetch_busy) busy_n++;
      tick();
      if (k == 0) chk("w3_addr", 32'(imem_addr), 32'h1);
      if (ir !== prev) ir_upd++;
      prev = ir;
    end
    ir_load = 1'b0;
    imem_ack = 1'b0;
    chk("w3_busy_cnt", busy_n, 4);
    chk("w3_ir_upd", ir_upd, 1);
    chk("w3_ir", ir, 32'h12345678);

    // PC update / branch vector table
    for (int i = 0; i < 10; i++) begin
      load_stat(4'hF);
      fetch0({4'h4, 4'hF, 8'h00, tv[i].pc0});
      pcw(1'b1, 1'b1);
      chk({tv[i].name, "_pc0"}, 32'(pc), 32'(tv[i].pc0));
      load_stat(tv[i].st);
      chk({tv[i].name, "_stat"}, 32'(stat), 32'(tv[i].st));
      fetch0(tv[i].w);
      chk({tv[i].name, "_opc"}, 32'(opcode), 32'(tv[i].w[31:28]));
      chk({tv[i].name, "_mm"}, 32'(mm), 32'(tv[i].w[27:24]));
      pcw(tv[i].ps, tv[i].bs);
      chk({tv[i].name, "_pc"}, 32'(pc), 32'(tv[i].exp_pc));
    end

    // same-cycle stat_en must not affect the branch decision
    load_stat(4'h2);
    fetch0(32'h42000055);
    stat_en = 1'b1;
    stat_in = 4'h0;
    pcw(1'b1, 1'b1);
    stat_en = 1'b0;
    chk("oldstat_pc", 32'(pc), 32'h0055);
    chk("oldstat_st", 32'(stat), 32'h0);

    // timeout: no ack ever
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && imem_req; c++) begin
      n++;
      tick();
    end
    chk("tmo_req_cycles", n, 16);
    chk("tmo_ir", ir, 32'h0);
    chk("tmo_err", 32'(fetch_err), 32'h1);
    chk("tmo_req", 32'(imem_req), 32'h0);
    fetch0(32'h11110000);
    chk("tmo_sticky", 32'(fetch_err), 32'h1);
    chk("tmo_ir2", ir, 32'h11110000);
    pcw(1'b0, 1'b0);
    chk("tmo_pc", 32'(pc), 32'h0056);

    // pc_rst beats pc_write, ir_load, ack
    pc_rst = 1'b1;
    pc_write = 1'b1;
    ir_load = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hFFFFFFFF;
    tick();
    pc_rst = 1'b0;
    pc_write = 1'b0;
    ir_load = 1'b0;
    imem_ack = 1'b0;
    chk("pcrst_pc", 32'(pc), 32'h0);
    chk("pcrst_err", 32'(fetch_err), 32'h0);
    chk("pcrst_req", 32'(imem_req), 32'h0);
    chk("pcrst_ir", ir, 32'h11110000);

    // async reset mid-REQ
    pcw(1'b0, 1'b0);
    pcw(1'b0, 1'b0);
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    chk("ar_req_up", 32'(imem_req), 32'h1);
    chk("ar_addr", 32'(imem_addr), 32'h2);
    #2;
    rst_f = 1'b0;
    #1;
    chk("ar_req_dn", 32'(imem_req), 32'h0);
    chk("ar_pc", 32'(pc), 32'h0);
    chk("ar_ir", ir, 32'h0);
    @(negedge clk);
    rst_f = 1'b1;
    tick();
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    chk("ar_refetch_addr", 32'(imem_addr), 32'h0);
    chk("ar_refetch_req", 32'(imem_req), 32'h1);
    imem_ack = 1'b1;
    imem_rdata = 32'h0A0B0C0D;
    tick();
    imem_ack = 1'b0;
    chk("ar_refetch_ir", ir, 32'h0A0B0C0D);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
